cpu_clk_ctrl: RTL and testbench

- Clock-enable sequencer for the Z8 SoC core.
- Replaces the free-running counter tap that drives the SoC clock today. The core then runs on the system clock and is gated by a one-cycle enable from this block.
- Provides three modes: RUN (programmable divide rate), HALT, and single-STEP.
- Modes are driven by two raw push-buttons on the board; the block sits in top between the board pins and the SoC.

---
 rtl/cpu_clk_ctrl.sv | 100 ++++++++++
 tb/tb_cpu_clk_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: clock-enable sequencer (RUN/HALT/STEP) for the SoC core; optional CPU_CE_COUNT_EN adds ce_count
module cpu_clk_ctrl #(
  parameter int DIV_WIDTH = 21,
  parameter int DB_WIDTH  = 16,
  parameter int DB_CYCLES = 40000,
  parameter int START_RUN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_run_raw,
  input  logic                 btn_step_raw,
  input  logic [DIV_WIDTH-1:0] div_max,
  output logic                 cpu_ce,
  output logic                 running
`ifdef CPU_CE_COUNT_EN
  ,
  output logic [15:0]          ce_count
`endif
);
  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;
  localparam state_t RESET_STATE = (START_RUN != 0) ? S_RUN : S_HALT;
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);
  // bit 0 = run button, bit 1 = step button
  logic [1:0]          sync1, sync2, db, press;
  logic [DB_WIDTH-1:0] db_cnt [2];
  state_t              state, state_next;
  logic [DIV_WIDTH-1:0] div_cnt, div_cnt_next;
  logic                ce_next;
  logic                run_ev, step_ev;
  assign run_ev  = press[0];
  assign step_ev = press[1];
  // two-flop synchronisers, debounce counters and one-cycle press pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_step_raw, btn_run_raw};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else
          db_cnt[i] <= db_cnt[i] + DB_WIDTH'(1);
      end
    end
  // next state, divider and enable; a run press beats both a pending tick and a step
  always_comb begin
    state_next   = state;
    ce_next      = 1'b0;
    div_cnt_next = '0;
    case (state)
      S_RUN:
        if (run_ev)
          state_next = S_HALT;
        else begin
          ce_next      = div_cnt >= div_max;
          div_cnt_next = ce_next ? '0 : div_cnt + DIV_WIDTH'(1);
        end
      S_HALT: begin
        state_next = run_ev ? S_RUN : step_ev ? S_STEP : S_HALT;
        ce_next    = step_ev && !run_ev;
      end
      S_STEP:
        state_next = S_HALT;
      default:
        state_next = S_HALT;
    endcase
  end
  // state, divider and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= RESET_STATE;
      div_cnt <= '0;
      cpu_ce  <= 1'b0;
      running <= (START_RUN != 0);
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
      cpu_ce  <= ce_next;
      running <= state_next == S_RUN;
    end
`ifdef CPU_CE_COUNT_EN
  // pulse counter trailing cpu_ce by one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      ce_count <= '0;
    else
      ce_count <= ce_count + {15'd0, cpu_ce};
`endif
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed bench for cpu_clk_ctrl with DB_CYCLES=4, DIV_WIDTH=8, START_RUN=1
module tb_cpu_clk_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run_raw = 1'b0;
  logic       btn_step_raw = 1'b0;
  logic [7:0] div_max = 8'd3;
  logic       cpu_ce;
  logic       running;
`ifdef CPU_CE_COUNT_EN
  logic [15:0] ce_count;
`endif
  int errors = 0;
  int checks = 0;

  cpu_clk_ctrl #(.DIV_WIDTH(8), .DB_WIDTH(16), .DB_CYCLES(4), .START_RUN(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_run_raw(btn_run_raw),
    .btn_step_raw(btn_step_raw),
    .div_max(div_max),
    .cpu_ce(cpu_ce),
    .running(running)
`ifdef CPU_CE_COUNT_EN
    ,
    .ce_count(ce_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int pulses;
    repeat (3) tick;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b want=0", cpu_ce); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_running got=%b want=1", running); end
    checks++; if (dut.div_cnt !== 8'd0) begin errors++; $display("FAIL reset_div_cnt got=%0d want=0", dut.div_cnt); end
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 44; k++) begin
      tick;
      checks++;
      if (cpu_ce !== (k % 4 == 0)) begin errors++; $display("FAIL run_div3 tick=%0d got=%b want=%b", k, cpu_ce, k % 4 == 0); end
      if (k >= 5 && cpu_ce === 1'b1) pulses++;
    end
    checks++; if (pulses != 10) begin errors++; $display("FAIL run_40cyc pulses=%0d want=10", pulses); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got=%b want=1", running); end
  endtask

  task automatic test_run_bounce;
    int bad;
    tick;
    btn_run_raw = 1'b1; tick;
    btn_run_raw = 1'b0; tick;
    btn_run_raw = 1'b1; tick;
    btn_run_raw = 1'b0; tick;
    btn_run_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL bounce_early tick=%0d running=%b want=1", k, running); end
    end
    tick;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL bounce_halt running=%b want=0", running); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL bounce_suppress ce=%b want=0", cpu_ce); end
    repeat (3) tick;
    btn_run_raw = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (cpu_ce !== 1'b0 || running !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL halt_quiet bad_cycles=%0d want=0", bad); end
  endtask

  task automatic test_step;
    int bad;
    for (int rep = 0; rep < 2; rep++) begin
      btn_step_raw = 1'b1;
      bad = 0;
      for (int k = 1; k <= 6; k++) begin
        tick;
        if (cpu_ce !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL step_early rep=%0d bad=%0d want=0", rep, bad); end
      tick;
      checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL step_pulse rep=%0d ce=%b want=1", rep, cpu_ce); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_running rep=%0d got=%b want=0", rep, running); end
      bad = 0;
      for (int k = 0; k < (rep == 0 ? 43 : 1); k++) begin
        tick;
        if (cpu_ce !== 1'b0 || running !== 1'b0) bad++;
      end
      btn_step_raw = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick;
        if (cpu_ce !== 1'b0 || running !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL step_hold rep=%0d bad=%0d want=0", rep, bad); end
    end
  endtask

  task automatic test_simultaneous;
    int bad;
    div_max = 8'd3;
    btn_run_raw = 1'b1;
    btn_step_raw = 1'b1;
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      if (cpu_ce !== 1'b0) bad++;
      if (k == 6) begin
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL simul_pre running=%b want=0", running); end
      end
      if (k == 7) begin
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL simul_run running=%b want=1", running); end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL simul_no_ce bad=%0d want=0", bad); end
    tick;
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL simul_first_pulse ce=%b want=1", cpu_ce); end
    btn_run_raw = 1'b0;
    btn_step_raw = 1'b0;
    repeat (10) tick;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL simul_release running=%b want=1", running); end
  endtask

  task automatic test_div_change;
    int bad;
    bit found;
    div_max = 8'd200;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick;
      if (cpu_ce === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL div200_timeout got=no_pulse want=pulse"); end
    btn_step_raw = 1'b1;
    bad = 0;
    for (int k = 1; k <= 150; k++) begin
      tick;
      if (k == 20) btn_step_raw = 1'b0;
      if (cpu_ce !== 1'b0 || running !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL step_in_run bad=%0d want=0", bad); end
    checks++; if (dut.div_cnt !== 8'd150) begin errors++; $display("FAIL div_cnt150 got=%0d want=150", dut.div_cnt); end
    div_max = 8'd10;
    tick;
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL div_shrink_ce got=%b want=1", cpu_ce); end
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      if (cpu_ce !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL div11_gap bad=%0d want=0", bad); end
    tick;
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL div11_pulse got=%b want=1", cpu_ce); end
  endtask

  task automatic test_reset_mid_run;
    div_max = 8'd0;
    tick;
    tick;
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL div0_ce got=%b want=1", cpu_ce); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL async_ce got=%b want=0", cpu_ce); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL async_running got=%b want=1", running); end
    div_max = 8'd5;
    tick;
    rst_n = 1'b1;
    repeat (3) tick;
    checks++; if (dut.div_cnt !== 8'd3) begin errors++; $display("FAIL div_cnt3 got=%0d want=3", dut.div_cnt); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (dut.div_cnt !== 8'd0) begin errors++; $display("FAIL async_div_cnt got=%0d want=0", dut.div_cnt); end
    tick;
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      checks++;
      if (cpu_ce !== (k == 6)) begin errors++; $display("FAIL restart tick=%0d got=%b want=%b", k, cpu_ce, k == 6); end
    end
  endtask

`ifdef CPU_CE_COUNT_EN
  task automatic test_ce_count_wrap;
    rst_n = 1'b0;
    div_max = 8'd0;
    tick;
    checks++; if (ce_count !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d want=0", ce_count); end
    rst_n = 1'b1;
    tick;
    tick;
    checks++; if (ce_count !== 16'd1) begin errors++; $display("FAIL cnt_first got=%0d want=1", ce_count); end
    repeat (65539) tick;
    checks++; if (ce_count !== 16'd4) begin errors++; $display("FAIL cnt_wrap got=%0d want=4", ce_count); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ce_count !== 16'd0) begin errors++; $display("FAIL cnt_async got=%0d want=0", ce_count); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL cnt_async_ce got=%b want=0", cpu_ce); end
    checks++; if (dut.div_cnt !== 8'd0) begin errors++; $display("FAIL cnt_async_div got=%0d want=0", dut.div_cnt); end
    tick;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_run_bounce;
    test_step;
    test_simultaneous;
    test_div_change;
    test_reset_mid_run;
`ifdef CPU_CE_COUNT_EN
    test_ce_count_wrap;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
